mul_sequencer: RTL and testbench

//   Multi-cycle shift-add sequencer for the R-type MUL op (alu_control 4'b0110).

---
 rtl/mul_sequencer.sv | 95 +++++++++
 tb/tb_mul_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for the R-type MUL op, beside the execute-stage ALU.
// Retires one multiplier bit per cycle and returns the low XLEN bits of the product.
module mul_sequencer #(
  parameter int          XLEN     = 32,
  parameter logic [3:0]  MUL_CODE = 4'b0110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            regwrite,
  output logic            stall_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]   mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [CW-1:0]     count_reg;
  logic [4:0]        rd_reg;
  logic              accept;

  assign accept = (state_reg == IDLE) && req_valid && (alu_control == MUL_CODE) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Flush outranks both the response handshake and the busy-count expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = BUSY;
      BUSY: begin
        if (flush)                 state_next = IDLE;
        else if (count_reg == '0)  state_next = DONE;
      end
      DONE: begin
        if (flush || resp_ready)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      rd_reg     <= '0;
    end else if (accept) begin
      acc_reg    <= '0;
      mcand_reg  <= op_a;
      mplier_reg <= op_b;
      count_reg  <= CW'(XLEN - 1);
      rd_reg     <= rd_in;
    end else if (state_reg == BUSY && !flush) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - 1'b1;
    end
  end

  // Handshake and stall outputs depend on registered state only, never on inputs.
  assign req_ready  = (state_reg == IDLE);
  assign stall_o    = (state_reg != IDLE);
  assign resp_valid = (state_reg == DONE);
  assign regwrite   = (state_reg == DONE) && (rd_reg != 5'd0);
  assign result     = acc_reg;
  assign rd_out     = rd_reg;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: products, latency, flush, backpressure and async reset.
module tb_mul_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      alu_control = 4'd0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic [4:0]      rd_in = '0;
  logic            flush = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            regwrite;
  logic            stall_o;

  int checks = 0;
  int failures = 0;

  mul_sequencer #(.XLEN(XLEN), .MUL_CODE(4'b0110)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .rd_out(rd_out), .regwrite(regwrite), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".req_ready"},  64'(req_ready),  64'd1);
    check({tag, ".stall_o"},    64'(stall_o),    64'd0);
    check({tag, ".resp_valid"}, 64'(resp_valid), 64'd0);
  endtask

  // Present a MUL, wait for the response, optionally hold it with resp_ready low.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int hold);
    int edges;
    @(negedge clk);
    op_a = a; op_b = b; rd_in = rd; alu_control = 4'b0110; req_valid = 1'b1;
    resp_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    #1 req_valid = 1'b0;
    check({tag, ".stall_after_accept"}, 64'(stall_o), 64'd1);
    while (!resp_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check({tag, ".latency"},  64'(edges),    64'd33);
    check({tag, ".result"},   64'(result),   64'(exp));
    check({tag, ".rd_out"},   64'(rd_out),   64'(rd));
    check({tag, ".regwrite"}, 64'(regwrite), 64'(rd != 5'd0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"},  64'(resp_valid), 64'd1);
      check({tag, ".hold_result"}, 64'(result),     64'(exp));
      check({tag, ".hold_rd"},     64'(rd_out),     64'(rd));
      check({tag, ".hold_stall"},  64'(stall_o),    64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle({tag, ".after_handshake"});
    resp_ready = 1'b0;
  endtask

  initial begin
    int seen;
    // Reset values while rst_n is held low
    #12;
    check_idle("reset");
    check("reset.result",   64'(result),   64'd0);
    check("reset.rd_out",   64'(rd_out),   64'd0);
    check("reset.regwrite", 64'(regwrite), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul("mul7x6",  32'd7,          32'd6,          5'd5,  32'd42,         0);
    run_mul("mulFFxFF",32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0001,  0);
    run_mul("mul8000x2",32'h8000_0000, 32'd2,          5'd0,  32'd0,          0);
    run_mul("mul_bp",  32'd1000,       32'd3000,       5'd31, 32'd3000000,    5);

    // Non-MUL op must be ignored
    @(negedge clk);
    alu_control = 4'b0010; op_a = 32'd3; op_b = 32'd4; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_idle("add_ignored");
    end
    req_valid = 1'b0;

    // Flush in BUSY cycle 10
    @(negedge clk);
    alu_control = 4'b0110; op_a = 32'd5; op_b = 32'd5; rd_in = 5'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_idle("flush");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    check("flush.no_resp", 64'(seen), 64'd0);
    run_mul("post_flush", 32'd3, 32'd4, 5'd7, 32'd12, 0);

    // Async reset in BUSY cycle 20
    @(negedge clk);
    op_a = 32'd9; op_b = 32'd9; rd_in = 5'd9; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    check("async_reset.result",   64'(result),   64'd0);
    check("async_reset.rd_out",   64'(rd_out),   64'd0);
    check("async_reset.regwrite", 64'(regwrite), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("mul12x12", 32'd12, 32'd12, 5'd12, 32'd144, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
